// File: rtl/port_tx_drain.sv
// Transmit frame drain: pops a length word per frame, streams that many bytes to the MAC over AXI-Stream
// with tlast and an inter-frame gap. Optional macro PORT_TX_PAD_EN zero-pads short frames to 60 bytes.
module port_tx_drain #(
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LEN_WIDTH-1:0] len_dout,
  input  logic                 len_empty,
  output logic                 len_ren,
  input  logic [7:0]           data_dout,
  input  logic                 data_empty,
  output logic                 data_ren,
  output logic [7:0]           tx_axis_tdata,
  output logic                 tx_axis_tvalid,
  output logic                 tx_axis_tlast,
  input  logic                 tx_axis_tready,
  output logic [31:0]          frames_sent,
  output logic [31:0]          frames_dropped,
  output logic                 busy
);

  // Handshake: a beat transfers when tvalid & tready on a rising edge; tvalid never depends on tready
  // and, once raised, holds until accepted unless the byte FIFO runs empty.

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP, S_GAP} state_t;

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  typedef logic [GAP_W-1:0] gap_t;
  localparam gap_t GAP_LOAD = gap_t'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] remaining;
  gap_t                 gap_cnt;

  logic len_pop, len_zero, len_big;
  logic send_beat, frame_done, drop_pop, drop_done;
  logic padding;

`ifdef PORT_TX_PAD_EN
  logic [5:0] sent_cnt;
  assign padding = (state == S_SEND) && (remaining == '0);
`else
  assign padding = 1'b0;
`endif

  assign len_pop    = (state == S_IDLE) && !len_empty && !reset;
  assign len_zero   = (len_dout == '0);
  assign len_big    = (32'(len_dout) > MAX_LEN_U);
  assign send_beat  = (state == S_SEND) && tx_axis_tvalid && tx_axis_tready;
  assign frame_done = send_beat && tx_axis_tlast;
  assign drop_pop   = (state == S_DROP) && !data_empty;
  assign drop_done  = drop_pop && (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (len_pop) begin
          if (len_zero)     state_next = S_IDLE;
          else if (len_big) state_next = S_DROP;
          else              state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (frame_done) state_next = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_DROP: begin
        if (drop_done) state_next = S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == '0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    len_ren        = 1'b0;
    data_ren       = 1'b0;
    tx_axis_tdata  = 8'h00;
    tx_axis_tvalid = 1'b0;
    tx_axis_tlast  = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_IDLE: len_ren = len_pop;
      S_SEND: begin
`ifdef PORT_TX_PAD_EN
        // Once the stored bytes are exhausted the frame continues with zero fill up to 60 bytes.
        tx_axis_tvalid = padding || !data_empty;
        tx_axis_tdata  = padding ? 8'h00 : data_dout;
        tx_axis_tlast  = tx_axis_tvalid &&
                         (padding ? (sent_cnt == 6'd59)
                                  : ((remaining == LEN_WIDTH'(1)) && (sent_cnt >= 6'd59)));
        data_ren       = tx_axis_tvalid && tx_axis_tready && !padding;
`else
        tx_axis_tvalid = !data_empty;
        tx_axis_tdata  = data_dout;
        tx_axis_tlast  = tx_axis_tvalid && (remaining == LEN_WIDTH'(1));
        data_ren       = tx_axis_tvalid && tx_axis_tready;
`endif
      end
      S_DROP: data_ren = !data_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining      <= '0;
      gap_cnt        <= '0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      if (len_pop) begin
        remaining <= len_dout;
        if (len_zero) frames_dropped <= frames_dropped + 32'd1;
      end
      if (send_beat && !padding && (remaining != '0)) remaining <= remaining - LEN_WIDTH'(1);
      if (frame_done) begin
        frames_sent <= frames_sent + 32'd1;
        gap_cnt     <= GAP_LOAD;
      end
      if (drop_pop && (remaining != '0)) remaining <= remaining - LEN_WIDTH'(1);
      if (drop_done) frames_dropped <= frames_dropped + 32'd1;
      if ((state == S_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - gap_t'(1);
    end
  end

`ifdef PORT_TX_PAD_EN
  // Bytes emitted so far in the current frame, saturating once the minimum size is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_cnt <= '0;
    end else begin
      if (len_pop) sent_cnt <= '0;
      else if (send_beat && (sent_cnt < 6'd60)) sent_cnt <= sent_cnt + 6'd1;
    end
  end
`endif

endmodule

// File: tb/tb_port_tx_drain.sv
// Bench for port_tx_drain: FWFT FIFO models, table of frames, scoreboard of expected beats,
// plus hand sequences for gap timing, mid-frame starvation, reset and padding.
module tb_port_tx_drain;
  localparam int LW   = 16;
  localparam int MAXL = 1514;
  localparam int IFG  = 12;

  logic          clk, reset;
  logic [LW-1:0] len_dout;
  logic          len_empty, len_ren;
  logic [7:0]    data_dout;
  logic          data_empty, data_ren;
  logic [7:0]    tx_axis_tdata;
  logic          tx_axis_tvalid, tx_axis_tlast, tx_axis_tready;
  logic [31:0]   frames_sent, frames_dropped;
  logic          busy;

  port_tx_drain #(.LEN_WIDTH(LW), .MAX_LEN(MAXL), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .reset(reset),
    .len_dout(len_dout), .len_empty(len_empty), .len_ren(len_ren),
    .data_dout(data_dout), .data_empty(data_empty), .data_ren(data_ren),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tlast(tx_axis_tlast), .tx_axis_tready(tx_axis_tready),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat: {pad, last, data}
  logic [9:0]    exp_q[$];
  logic [LW-1:0] len_q[$];
  logic [7:0]    data_q[$];

  int          checks = 0;
  int          fails  = 0;
  int          cyc = 0;
  int          tready_mode = 0;
  int          ren_count = 0;
  int          tvalid_cnt = 0;
  int          last_end_cyc = 0;
  int          gap_meas = -1;
  bit          wait_first = 0;
  bit          prev_stall = 0;
  logic [31:0] exp_sent = 0;
  logic [31:0] exp_dropped = 0;

  typedef struct {
    int len;
    int mode;
    int sent_inc;
    int drop_inc;
    int ren_exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bytes(input int from, input int upto);
    for (int i = from; i < upto; i++) data_q.push_back(8'(i));
  endtask

  task automatic push_frame(input int len, input int avail);
    len_q.push_back(LW'(len));
    push_bytes(0, avail);
    if (len > 0 && len <= MAXL) begin
      int total;
      total = len;
`ifdef PORT_TX_PAD_EN
      if (len < 60) total = 60;
`endif
      for (int i = 0; i < total; i++)
        exp_q.push_back({(i >= len), (i == total - 1), (i < len) ? 8'(i) : 8'h00});
    end
  endtask

  // One clock: drive FIFO heads at negedge, sample #1 later, update models before the rising edge.
  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    len_empty  = (len_q.size() == 0);
    len_dout   = len_empty ? '0 : len_q[0];
    data_empty = (data_q.size() == 0);
    data_dout  = data_empty ? 8'h00 : data_q[0];
    case (tready_mode)
      1:       tx_axis_tready = (cyc % 2 == 0);
      2:       tx_axis_tready = 1'($urandom_range(0, 1));
      default: tx_axis_tready = 1'b1;
    endcase
    #1;
    if (len_ren) begin
      check("len_ren_on_empty", 32'(len_empty), 32'd0);
      if (!len_empty) void'(len_q.pop_front());
    end
    if (data_ren) begin
      check("data_ren_on_empty", 32'(data_empty), 32'd0);
      if (!data_empty) void'(data_q.pop_front());
      ren_count++;
    end
    if (prev_stall && !data_empty) check("tvalid_held", 32'(tx_axis_tvalid), 32'd1);
    if (!tx_axis_tvalid && tx_axis_tlast) check("tlast_without_tvalid", 32'(tx_axis_tlast), 32'd0);
    tvalid_cnt += int'(tx_axis_tvalid);
    if (tx_axis_tvalid && wait_first) begin
      gap_meas   = cyc - last_end_cyc;
      wait_first = 0;
    end
    if (tx_axis_tvalid && !tx_axis_tready) check("data_ren_on_stall", 32'(data_ren), 32'd0);
    if (tx_axis_tvalid && tx_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(tx_axis_tvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tdata", 32'(tx_axis_tdata), 32'(e[7:0]));
        check("tlast", 32'(tx_axis_tlast), 32'(e[8]));
        check("data_ren_on_accept", 32'(data_ren), 32'(!e[9]));
        if (tx_axis_tlast) begin
          last_end_cyc = cyc;
          wait_first   = 1;
        end
      end
    end
    prev_stall = tx_axis_tvalid && !tx_axis_tready;
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(len_q.size() == 0 && data_q.size() == 0 && exp_q.size() == 0 && !busy) && n < budget);
    check("drain_done", 32'(len_q.size() == 0 && data_q.size() == 0 && exp_q.size() == 0 && !busy), 32'd1);
    step();
    step();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frames_sent"}, frames_sent, exp_sent);
    check({tag, "_frames_dropped"}, frames_dropped, exp_dropped);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_len_ren"}, 32'(len_ren), 32'd0);
    check({tag, "_data_ren"}, 32'(data_ren), 32'd0);
    check({tag, "_tvalid"}, 32'(tx_axis_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(tx_axis_tlast), 32'd0);
    check({tag, "_tdata"}, 32'(tx_axis_tdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frames_sent"}, frames_sent, 32'd0);
    check({tag, "_frames_dropped"}, frames_dropped, 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{len: 64,   mode: 0, sent_inc: 1, drop_inc: 0, ren_exp: 64};
    vecs[1] = '{len: 10,   mode: 1, sent_inc: 1, drop_inc: 0, ren_exp: 10};
    vecs[2] = '{len: 1600, mode: 0, sent_inc: 0, drop_inc: 1, ren_exp: 1600};
    vecs[3] = '{len: 64,   mode: 0, sent_inc: 1, drop_inc: 0, ren_exp: 64};
    vecs[4] = '{len: 0,    mode: 0, sent_inc: 0, drop_inc: 1, ren_exp: 0};
    vecs[5] = '{len: 1,    mode: 1, sent_inc: 1, drop_inc: 0, ren_exp: 1};
    vecs[6] = '{len: 1514, mode: 0, sent_inc: 1, drop_inc: 0, ren_exp: 1514};
    vecs[7] = '{len: 1515, mode: 2, sent_inc: 0, drop_inc: 1, ren_exp: 1515};
    vecs[8] = '{len: 60,   mode: 2, sent_inc: 1, drop_inc: 0, ren_exp: 60};

    reset = 1'b1;
    len_empty = 1'b1; len_dout = '0;
    data_empty = 1'b1; data_dout = 8'h00;
    tx_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Back-to-back frames: gap from tlast to next tvalid is IFG idle cycles plus the pop cycle.
    tready_mode = 0;
    push_frame(64, 64);
    push_frame(100, 100);
    gap_meas = -1;
    wait_first = 0;
    exp_sent += 2;
    run_until_idle(1000);
    check("ifg_spacing", 32'(gap_meas), 32'(IFG + 2));
    check_counters("b2b");

    foreach (vecs[k]) begin
      tready_mode = vecs[k].mode;
      ren_count = 0;
      push_frame(vecs[k].len, vecs[k].len);
      exp_sent    += 32'(vecs[k].sent_inc);
      exp_dropped += 32'(vecs[k].drop_inc);
      run_until_idle(5000);
      check($sformatf("vec%0d_data_ren_count", k), 32'(ren_count), 32'(vecs[k].ren_exp));
      check_counters($sformatf("vec%0d", k));
    end

    // Byte FIFO starves after byte 20 of a 50-byte frame for 30 cycles.
    tready_mode = 0;
    push_frame(50, 20);
    n = 0;
    while (exp_q.size() > 30 && n < 200) begin
      step();
      n++;
    end
    check("stall_reached_byte20", 32'(exp_q.size()), 32'd30);
    tvalid_cnt = 0;
    repeat (30) step();
    check("stall_tvalid_low", 32'(tvalid_cnt), 32'd0);
    check("stall_no_early_done", frames_sent, exp_sent);
    push_bytes(20, 50);
    exp_sent += 1;
    run_until_idle(500);
    check_counters("stall");

    // Reset in the middle of a frame; FIFOs are flushed by the same reset.
    push_frame(64, 64);
    n = 0;
    while (exp_q.size() > 34 && n < 200) begin
      step();
      n++;
    end
    check("reset_reached_byte30", 32'(exp_q.size()), 32'd34);
    reset = 1'b1;
    len_q.delete();
    data_q.delete();
    exp_q.delete();
    step();
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    reset = 1'b0;
    exp_sent = 0;
    exp_dropped = 0;
    prev_stall = 0;
    wait_first = 0;
    ren_count = 0;
    push_frame(20, 20);
    exp_sent += 1;
    run_until_idle(500);
    check("post_reset_data_ren_count", 32'(ren_count), 32'd20);
    check_counters("post_reset");

`ifdef PORT_TX_PAD_EN
    ren_count = 0;
    tvalid_cnt = 0;
    tready_mode = 0;
    push_frame(42, 42);
    exp_sent += 1;
    run_until_idle(500);
    check("pad_data_ren_count", 32'(ren_count), 32'd42);
    check("pad_beat_count", 32'(tvalid_cnt), 32'd60);
    check_counters("pad");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
